// File: rtl/sbrk_input_pkg.sv
// Shared types and helpers for the Super Breakout paddle-input path.
package sbrk_input_pkg;

    // Which quadrature source currently drives the core's encoder input.
    typedef enum logic {
        SRC_JOY = 1'b0,
        SRC_IO  = 1'b1
    } src_t;

    // Per-cycle decode of one quadrature source.
    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        INC     = 2'd1,
        DEC     = 2'd2,
        ILLEGAL = 2'd3
    } step_t;

    // Source-selection FSM states.
    typedef enum logic {
        SEL_JOY = 1'b0,
        SEL_IO  = 1'b1
    } sel_state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Next Gray code in the given direction; forward order is 00->01->11->10->00.
    function automatic logic [1:0] gray_next(input logic [1:0] code, input logic dir);
        logic [1:0] nxt;
        if (dir) begin
            case (code)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (code)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Turns one synchronised quadrature stream into registered step events.
// The previous-sample register runs every cycle; decoding only starts once
// it holds a sample taken from valid (post-reset) input data.
module quad_step_decoder
    import sbrk_input_pkg::*;
(
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  logic       in_valid,
    input  logic [1:0] quad,
    output step_t      step
);

    logic [1:0] prev_q;
    logic       have_prev_q;
    step_t      step_d;

    // Classify the transition from the previous sample to the current one.
    always_comb begin
        step_d = ZERO;
        if (have_prev_q && in_valid) begin
            if (quad == prev_q) begin
                step_d = ZERO;
            end else if (quad == gray_next(prev_q, DIR_FWD)) begin
                step_d = INC;
            end else if (quad == gray_next(prev_q, DIR_REV)) begin
                step_d = DEC;
            end else begin
                step_d = ILLEGAL;
            end
        end
    end

    // Sample history and registered decode result.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_q      <= 2'b00;
            have_prev_q <= 1'b0;
            step        <= ZERO;
        end else begin
            prev_q      <= quad;
            have_prev_q <= in_valid;
            step        <= step_d;
        end
    end

endmodule

// File: rtl/quad_source_arbiter.sv
// Selects between the joy2quad and user-port encoders, accumulates accepted
// steps and re-emits them as a rate-limited, single-bit-change Gray stream.
//
// Handshake note: there is no valid/ready pair here. Each decoder presents
// one step per cycle unconditionally; the arbiter accepts or drops it in the
// same cycle, and excess steps beyond the accumulator range are discarded.
module quad_source_arbiter
    import sbrk_input_pkg::*;
#(
    parameter int HOLD_CYCLES = 12000,
    parameter int STEP_GAP    = 64,
    parameter int PEND_MAX    = 7
) (
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  logic [1:0] joy_quad,
    input  logic [1:0] io_quad,
    input  logic [1:0] force_src,
    output logic [1:0] enc_out,
    output logic       src_sel,
    output logic       switch_pulse,
    output logic       err_pulse
);

    localparam int IW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int PW = $clog2(PEND_MAX + 1) + 1;
    localparam int SW = PW + 2;

    localparam logic [IW-1:0]        IDLE_MAX = IW'(HOLD_CYCLES);
    localparam logic [GW-1:0]        GAP_LOAD = GW'(STEP_GAP - 1);
    localparam logic signed [SW-1:0] SUM_HI   = SW'(PEND_MAX);
    localparam logic signed [SW-1:0] SUM_LO   = SW'(-PEND_MAX);

    // Signed contribution of one decoded step; illegal counts as nothing.
    function automatic logic signed [SW-1:0] step_delta(input step_t s);
        case (s)
            INC:     return SW'(1);
            DEC:     return SW'(-1);
            default: return SW'(0);
        endcase
    endfunction

    // Input conditioning
    logic [1:0] joy_r;
    logic [1:0] io_s1;
    logic [1:0] io_s2;
    logic       joy_vld;
    logic       io_vld1;
    logic       io_vld2;

    // Decoder outputs
    step_t joy_step;
    step_t io_step;

    // FSM and datapath state
    sel_state_t             state_q;
    sel_state_t             state_d;
    logic signed [PW-1:0]   pending;
    logic signed [PW-1:0]   pending_d;
    logic [GW-1:0]          gap_cnt;
    logic [GW-1:0]          gap_d;
    logic [IW-1:0]          idle_cnt;
    logic [IW-1:0]          idle_d;
    logic [1:0]             enc_d;
    src_t                   cur_src;

    // Combinational helpers
    step_t                sel_step;
    step_t                oth_step;
    logic                 sel_act;
    logic                 oth_act;
    logic                 forced;
    logic                 switching;
    logic                 emit_now;
    logic signed [SW-1:0] pend_ext;
    logic signed [SW-1:0] accept;
    logic signed [SW-1:0] emit_delta;
    logic signed [SW-1:0] pend_sum;

    // joy_quad is already synchronous (one register); io_quad is raw (two flops).
    // The valid bits mark when each pipeline carries post-reset input data.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            joy_r   <= 2'b00;
            io_s1   <= 2'b00;
            io_s2   <= 2'b00;
            joy_vld <= 1'b0;
            io_vld1 <= 1'b0;
            io_vld2 <= 1'b0;
        end else begin
            joy_r   <= joy_quad;
            io_s1   <= io_quad;
            io_s2   <= io_s1;
            joy_vld <= 1'b1;
            io_vld1 <= 1'b1;
            io_vld2 <= io_vld1;
        end
    end

    quad_step_decoder u_joy_dec (
        .clk_sys  (clk_sys),
        .Reset_n  (Reset_n),
        .in_valid (joy_vld),
        .quad     (joy_r),
        .step     (joy_step)
    );

    quad_step_decoder u_io_dec (
        .clk_sys  (clk_sys),
        .Reset_n  (Reset_n),
        .in_valid (io_vld2),
        .quad     (io_s2),
        .step     (io_step)
    );

    // Source FSM next state, step acceptance, accumulator and emitter.
    always_comb begin
        sel_step   = (state_q == SEL_JOY) ? joy_step : io_step;
        oth_step   = (state_q == SEL_JOY) ? io_step  : joy_step;
        sel_act    = (sel_step != ZERO);
        oth_act    = (oth_step != ZERO);
        forced     = (force_src == 2'b01) || (force_src == 2'b10);

        state_d = state_q;
        if (force_src == 2'b01) begin
            state_d = SEL_JOY;
        end else if (force_src == 2'b10) begin
            state_d = SEL_IO;
        end else if (oth_act && !sel_act && (idle_cnt == IDLE_MAX)) begin
            state_d = (state_q == SEL_JOY) ? SEL_IO : SEL_JOY;
        end
        switching = (state_d != state_q);

        // On an auto switch the step that woke the new source is kept; a forced
        // switch starts from an empty accumulator.
        accept = '0;
        if (switching) begin
            if (!forced) begin
                accept = step_delta(oth_step);
            end
        end else begin
            accept = step_delta(sel_step);
        end

        // No emission in a switch cycle: the accumulator is being discarded.
        emit_now   = !switching && (gap_cnt == '0) && (pending != '0);
        emit_delta = '0;
        if (emit_now) begin
            emit_delta = pending[PW-1] ? SW'(-1) : SW'(1);
        end

        pend_ext = switching ? '0 : {{(SW-PW){pending[PW-1]}}, pending};
        pend_sum = pend_ext + accept - emit_delta;
        if (pend_sum > SUM_HI) begin
            pending_d = PW'(PEND_MAX);
        end else if (pend_sum < SUM_LO) begin
            pending_d = PW'(-PEND_MAX);
        end else begin
            pending_d = pend_sum[PW-1:0];
        end

        enc_d = enc_out;
        if (emit_now) begin
            enc_d = gray_next(enc_out, !pending[PW-1]);
        end

        gap_d = gap_cnt;
        if (emit_now) begin
            gap_d = GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_d = gap_cnt - GW'(1);
        end

        idle_d = idle_cnt;
        if (switching || sel_act) begin
            idle_d = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_d = idle_cnt + IW'(1);
        end
    end

    // Source FSM state register.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SEL_JOY;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, accumulator, encoder output and event pulses.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            pending      <= '0;
            gap_cnt      <= '0;
            idle_cnt     <= '0;
            enc_out      <= 2'b00;
            switch_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            pending      <= pending_d;
            gap_cnt      <= gap_d;
            idle_cnt     <= idle_d;
            enc_out      <= enc_d;
            switch_pulse <= switching;
            err_pulse    <= (sel_step == ILLEGAL);
        end
    end

    assign cur_src = (state_q == SEL_IO) ? SRC_IO : SRC_JOY;
    assign src_sel = cur_src;

endmodule
